// File: rtl/fetch_unit.sv
// SISC fetch unit: PC, IR and saved PC+1, branch-target generation,
// IR field decode and fetch/branch statistics counters.
module fetch_unit #(
   parameter int PC_WIDTH    = 16,
   parameter int INSTR_WIDTH = 32,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst_f,
   input  logic                   pc_rst,
   input  logic                   pc_write,
   input  logic                   pc_sel,
   input  logic                   br_sel,
   input  logic                   ir_load,
   input  logic [INSTR_WIDTH-1:0] imem_data,
   output logic [PC_WIDTH-1:0]    imem_addr,
   output logic [3:0]             opcode,
   output logic [3:0]             mm,
   output logic [3:0]             rd,
   output logic [3:0]             rs,
   output logic [3:0]             rt,
   output logic [15:0]            imm,
   output logic [PC_WIDTH-1:0]    pc_out,
   output logic [CNT_WIDTH-1:0]   fetch_count,
   output logic [CNT_WIDTH-1:0]   branch_count
);

   localparam logic [PC_WIDTH-1:0]  PC_ONE  = PC_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [PC_WIDTH-1:0]    pc_q;
   logic [PC_WIDTH-1:0]    pc_inc_q;
   logic [INSTR_WIDTH-1:0] ir_q;
   logic [CNT_WIDTH-1:0]   fcnt_q;
   logic [CNT_WIDTH-1:0]   bcnt_q;

   logic [PC_WIDTH-1:0]    pc_plus1;
   logic [PC_WIDTH-1:0]    seq;
   logic [PC_WIDTH-1:0]    tgt;
   logic [PC_WIDTH-1:0]    imm_sx;
   logic [PC_WIDTH-1:0]    imm_zx;
   logic [PC_WIDTH-1:0]    pc_nxt;
   logic                   br_taken;

   assign opcode = ir_q[31:28];
   assign mm     = ir_q[27:24];
   assign rd     = ir_q[23:20];
   assign rs     = ir_q[19:16];
   assign rt     = ir_q[15:12];
   assign imm    = ir_q[15:0];

   // Immediate is 16 bits; widen or truncate to the PC width.
   generate
      if (PC_WIDTH > 16) begin : g_wide
         assign imm_sx = {{(PC_WIDTH-16){imm[15]}}, imm};
         assign imm_zx = {{(PC_WIDTH-16){1'b0}}, imm};
      end else begin : g_narrow
         assign imm_sx = imm[PC_WIDTH-1:0];
         assign imm_zx = imm[PC_WIDTH-1:0];
      end
   endgenerate

   assign pc_plus1 = pc_q + PC_ONE;
   assign br_taken = pc_write & pc_sel;

   // A decode-time rewrite uses the saved PC+1 so the PC never
   // advances twice for one instruction.
   always_comb begin
      seq = pc_inc_q;
      if (ir_load)
         seq = pc_plus1;
   end

   always_comb begin
      tgt = pc_inc_q + imm_sx;
      if (br_sel)
         tgt = imm_zx;
   end

   always_comb begin
      pc_nxt = pc_q;
      unique case (1'b1)
         br_taken:            pc_nxt = tgt;
         pc_write & ~pc_sel:  pc_nxt = seq;
         default:             pc_nxt = pc_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         pc_q     <= '0;
         pc_inc_q <= '0;
         ir_q     <= '0;
         fcnt_q   <= '0;
         bcnt_q   <= '0;
      end else if (pc_rst) begin
         pc_q     <= '0;
         pc_inc_q <= '0;
         ir_q     <= '0;
         fcnt_q   <= '0;
         bcnt_q   <= '0;
      end else begin
         pc_q <= pc_nxt;
         if (ir_load) begin
            ir_q     <= imem_data;
            pc_inc_q <= pc_plus1;
            fcnt_q   <= fcnt_q + CNT_ONE;
         end
         if (br_taken)
            bcnt_q <= bcnt_q + CNT_ONE;
      end
   end

   assign imem_addr    = pc_q;
   assign pc_out       = pc_q;
   assign fetch_count  = fcnt_q;
   assign branch_count = bcnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed steps push expected state,
// a negedge monitor pops and compares against the DUT outputs.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_f = 1'b0;
   logic        pc_rst = 1'b0;
   logic        pc_write = 1'b0;
   logic        pc_sel = 1'b0;
   logic        br_sel = 1'b0;
   logic        ir_load = 1'b0;
   logic [31:0] imem_data = 32'h0;
   logic [15:0] imem_addr;
   logic [3:0]  opcode, mm, rd, rs, rt;
   logic [15:0] imm;
   logic [15:0] pc_out;
   logic [15:0] fetch_count;
   logic [15:0] branch_count;

   typedef struct {
      string       name;
      logic [15:0] pc;
      logic [31:0] ir;
      logic [15:0] fc;
      logic [15:0] bc;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;

   fetch_unit dut (
      .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst),
      .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel),
      .ir_load(ir_load), .imem_data(imem_data),
      .imem_addr(imem_addr), .opcode(opcode), .mm(mm),
      .rd(rd), .rs(rs), .rt(rt), .imm(imm), .pc_out(pc_out),
      .fetch_count(fetch_count), .branch_count(branch_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input string f,
                      input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s.%s: got %h want %h", nm, f, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk(e.name, "pc_out", 32'(pc_out), 32'(e.pc));
         chk(e.name, "imem_addr", 32'(imem_addr), 32'(e.pc));
         chk(e.name, "opcode", 32'(opcode), 32'(e.ir[31:28]));
         chk(e.name, "mm", 32'(mm), 32'(e.ir[27:24]));
         chk(e.name, "rd", 32'(rd), 32'(e.ir[23:20]));
         chk(e.name, "rs", 32'(rs), 32'(e.ir[19:16]));
         chk(e.name, "rt", 32'(rt), 32'(e.ir[15:12]));
         chk(e.name, "imm", 32'(imm), 32'(e.ir[15:0]));
         chk(e.name, "fetch_count", 32'(fetch_count), 32'(e.fc));
         chk(e.name, "branch_count", 32'(branch_count), 32'(e.bc));
      end
   end

   task automatic expect_st(input string nm, input logic [15:0] pc,
                            input logic [31:0] ir, input logic [15:0] fc,
                            input logic [15:0] bc);
      exp_t e;
      e.name = nm;
      e.pc = pc;
      e.ir = ir;
      e.fc = fc;
      e.bc = bc;
      q.push_back(e);
   endtask

   // Drive one cycle of strobes, then settle just past the edge.
   task automatic tick(input logic pw, input logic ps, input logic bs,
                       input logic il, input logic pr,
                       input logic [31:0] d);
      pc_write = pw;
      pc_sel = ps;
      br_sel = bs;
      ir_load = il;
      pc_rst = pr;
      imem_data = d;
      @(posedge clk);
      #1;
      pc_write = 1'b0;
      pc_sel = 1'b0;
      br_sel = 1'b0;
      ir_load = 1'b0;
      pc_rst = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] d);
      tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, d);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      #1;
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      #3;
      expect_st("async_rst", 16'h0, 32'h0, 16'd0, 16'd0);
      drain();
      #2 rst_f = 1'b1;
      @(posedge clk);
      #1;

      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      expect_st("pc_rst", 16'h0, 32'h0, 16'd0, 16'd0);
      fetch(32'h2100_0005);
      expect_st("fetch0", 16'h1, 32'h2100_0005, 16'd1, 16'd0);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      expect_st("decode0", 16'h1, 32'h2100_0005, 16'd1, 16'd0);

      fetch(32'h1000_0000);
      fetch(32'h3000_0000);
      expect_st("fetch2", 16'h3, 32'h3000_0000, 16'd3, 16'd0);
      fetch(32'h4123_4567);
      expect_st("fetch3", 16'h4, 32'h4123_4567, 16'd4, 16'd0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         expect_st("rewrite", 16'h4, 32'h4123_4567, 16'd4, 16'd0);
      end

      fetch(32'h5000_000F);
      tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      expect_st("abs_0f", 16'h000F, 32'h5000_000F, 16'd5, 16'd1);
      fetch(32'h6000_FFFD);
      expect_st("fetch_0f", 16'h0010, 32'h6000_FFFD, 16'd6, 16'd1);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      expect_st("rel_back", 16'h000D, 32'h6000_FFFD, 16'd6, 16'd2);

      fetch(32'h7000_FFFF);
      tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      expect_st("abs_ffff", 16'hFFFF, 32'h7000_FFFF, 16'd7, 16'd3);
      fetch(32'h8000_FFFE);
      expect_st("pc_wrap", 16'h0000, 32'h8000_FFFE, 16'd8, 16'd3);
      fetch(32'h9000_FFFE);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      expect_st("rel_wrap", 16'hFFFF, 32'h9000_FFFE, 16'd9, 16'd4);

      fetch(32'hA000_0040);
      tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      expect_st("abs_40", 16'h0040, 32'hA000_0040, 16'd10, 16'd5);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      expect_st("nowr_abs", 16'h0040, 32'hA000_0040, 16'd10, 16'd5);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      expect_st("nowr_rel", 16'h0040, 32'hA000_0040, 16'd10, 16'd5);

      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hB000_0010);
      expect_st("ld_only", 16'h0040, 32'hB000_0010, 16'd11, 16'd5);
      tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hC000_0005);
      expect_st("ld_and_br", 16'h0051, 32'hC000_0005, 16'd12, 16'd6);

      fetch(32'hD000_0022);
      tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      expect_st("abs_22", 16'h0022, 32'hD000_0022, 16'd13, 16'd7);
      drain();
      @(posedge clk);
      #3 rst_f = 1'b0;
      #1;
      expect_st("mid_rst", 16'h0, 32'h0, 16'd0, 16'd0);
      drain();
      #2 rst_f = 1'b1;
      @(posedge clk);
      #1;

      fetch(32'hE123_0007);
      expect_st("post_rst", 16'h1, 32'hE123_0007, 16'd1, 16'd0);
      tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
      expect_st("rst_prio", 16'h0, 32'h0, 16'd0, 16'd0);
      drain();

      for (int i = 0; i < 65535; i++)
         fetch(32'h0F0F_0001);
      expect_st("fc_ffff", 16'hFFFF, 32'h0F0F_0001, 16'hFFFF, 16'd0);
      fetch(32'h1234_5678);
      expect_st("fc_wrap", 16'h0000, 32'h1234_5678, 16'h0000, 16'd0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
